// File: rtl/pe_cluster_ctrl.sv
// Run controller for a PE cluster: streams weights then activations into the cluster, fires
// start, waits for completion and unloads the X_dim result words over a valid/ready port.
module pe_cluster_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned X_dim      = 5,
  parameter int unsigned W_WORDS    = 9,
  parameter int unsigned A_WORDS    = 35,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] filt_in,
  output logic [DATA_WIDTH-1:0] act_in,
  output logic                  load_en_wght,
  output logic                  load_en_act,
  output logic                  start,
  input  logic                  load_done,
  input  logic                  compute_done,
  input  logic [DATA_WIDTH-1:0] pe_out [X_dim],
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int unsigned MaxWords = (A_WORDS > W_WORDS) ? A_WORDS : W_WORDS;
  localparam int unsigned CntW     = $clog2(MaxWords + 1);
  localparam int unsigned WdW      = $clog2(TIMEOUT + 1);
  localparam int unsigned IdxW     = (X_dim > 1) ? $clog2(X_dim) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StLoadA,
    StWaitLoad,
    StStart,
    StCompute,
    StCapture,
    StUnload
  } state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [WdW-1:0]        wdog_q;
  logic [IdxW-1:0]       idx_q;
  logic [DATA_WIDTH-1:0] obuf_q [X_dim];
  logic                  accept;

  // Handshake-level outputs are pure decodes of the state register.
  always_comb begin
    cmd_ready  = (state_q == StIdle);
    din_ready  = (state_q == StLoadW) || (state_q == StLoadA);
    start      = (state_q == StStart);
    dout_valid = (state_q == StUnload);
    busy       = (state_q != StIdle);
    accept     = din_valid && din_ready;
    dout       = dout_valid ? obuf_q[idx_q] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      wdog_q       <= '0;
      idx_q        <= '0;
      filt_in      <= '0;
      act_in       <= '0;
      load_en_wght <= 1'b0;
      load_en_act  <= 1'b0;
      timeout_err  <= 1'b0;
      for (int i = 0; i < int'(X_dim); i++) obuf_q[i] <= '0;
    end else begin
      load_en_wght <= 1'b0;
      load_en_act  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            state_q     <= StLoadW;
            cnt_q       <= '0;
            timeout_err <= 1'b0;
          end
        end
        StLoadW: begin
          if (accept) begin
            filt_in      <= din;
            load_en_wght <= 1'b1;
            if (cnt_q == CntW'(W_WORDS - 1)) begin
              cnt_q   <= '0;
              state_q <= StLoadA;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StLoadA: begin
          if (accept) begin
            act_in      <= din;
            load_en_act <= 1'b1;
            if (cnt_q == CntW'(A_WORDS - 1)) begin
              cnt_q   <= '0;
              wdog_q  <= '0;
              state_q <= StWaitLoad;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StWaitLoad: begin
          // load_done only counts once the last activation pulse has left.
          if (load_done && !load_en_act) begin
            state_q <= StStart;
          end else if (wdog_q == WdW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state_q     <= StIdle;
          end else begin
            wdog_q <= wdog_q + WdW'(1);
          end
        end
        StStart: begin
          wdog_q  <= '0;
          state_q <= StCompute;
        end
        StCompute: begin
          if (compute_done) begin
            state_q <= StCapture;
          end else if (wdog_q == WdW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state_q     <= StIdle;
          end else begin
            wdog_q <= wdog_q + WdW'(1);
          end
        end
        StCapture: begin
          // One cycle of slack for the cluster's output register before latching.
          for (int i = 0; i < int'(X_dim); i++) obuf_q[i] <= pe_out[i];
          idx_q   <= '0;
          state_q <= StUnload;
        end
        StUnload: begin
          if (dout_ready) begin
            if (idx_q == IdxW'(X_dim - 1)) begin
              idx_q   <= '0;
              state_q <= StIdle;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_cluster_ctrl.sv
// Directed bench for pe_cluster_ctrl: table of full runs plus hand sequences for timeout,
// mid-run reset and a held command. Instance b uses a short watchdog for the timeout case.
module tb_pe_cluster_ctrl;

  localparam int DW = 16;
  localparam int XD = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid_a = 1'b0;
  logic          cmd_valid_b = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          load_done = 1'b0;
  logic          compute_done = 1'b0;
  logic          dout_ready = 1'b0;
  logic [DW-1:0] pe_out [XD];

  logic          a_cmd_ready, a_din_ready, a_load_en_wght, a_load_en_act, a_start;
  logic          a_dout_valid, a_busy, a_timeout_err;
  logic [DW-1:0] a_filt_in, a_act_in, a_dout;
  logic          b_cmd_ready, b_din_ready, b_load_en_wght, b_load_en_act, b_start;
  logic          b_dout_valid, b_busy, b_timeout_err;
  logic [DW-1:0] b_filt_in, b_act_in, b_dout;

  always #5 clk = ~clk;

  pe_cluster_ctrl dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_a), .cmd_ready(a_cmd_ready),
    .din(din), .din_valid(din_valid), .din_ready(a_din_ready),
    .filt_in(a_filt_in), .act_in(a_act_in), .load_en_wght(a_load_en_wght),
    .load_en_act(a_load_en_act), .start(a_start), .load_done(load_done),
    .compute_done(compute_done), .pe_out(pe_out), .dout(a_dout), .dout_valid(a_dout_valid),
    .dout_ready(dout_ready), .busy(a_busy), .timeout_err(a_timeout_err)
  );

  pe_cluster_ctrl #(.TIMEOUT(15)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ready(b_cmd_ready),
    .din(din), .din_valid(din_valid), .din_ready(b_din_ready),
    .filt_in(b_filt_in), .act_in(b_act_in), .load_en_wght(b_load_en_wght),
    .load_en_act(b_load_en_act), .start(b_start), .load_done(load_done),
    .compute_done(compute_done), .pe_out(pe_out), .dout(b_dout), .dout_valid(b_dout_valid),
    .dout_ready(dout_ready), .busy(b_busy), .timeout_err(b_timeout_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return a_din_ready;
      1:       return b_din_ready;
      2:       return a_start;
      3:       return b_start;
      default: return a_dout_valid;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string name);
    int n = 0;
    while (!sig(which) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!sig(which)) begin
      errors++;
      $display("FAIL wait %s: not seen within 200 cycles", name);
    end
  endtask

  // Load-pulse monitor for instance a: values must be consecutive from the run's base.
  bit            mon_en = 1'b0;
  logic [DW-1:0] mon_w, mon_a;
  int            n_w, n_a, n_start, n_dv_b;

  always @(negedge clk) begin
    if (mon_en) begin
      if (a_load_en_wght) begin
        chk("filt_in", a_filt_in, mon_w);
        mon_w = mon_w + 16'd1;
        n_w++;
      end
      if (a_load_en_act) begin
        chk("act_in", a_act_in, mon_a);
        mon_a = mon_a + 16'd1;
        n_a++;
      end
      if (a_start) n_start++;
    end
    if (b_dout_valid) n_dv_b++;
  end

  typedef struct {
    logic [DW-1:0]         w_base;
    logic [DW-1:0]         a_base;
    bit                    gapped;
    int                    bp_word;
    int                    bp_len;
    logic [XD-1:0][DW-1:0] pe;
    logic [XD-1:0][DW-1:0] exp;
  } vec_t;

  vec_t vecs [4];

  task automatic feed(input bit sel_b, input logic [DW-1:0] wb, input logic [DW-1:0] ab,
                      input bit gapped, input int n_act);
    for (int i = 0; i < 9 + n_act; i++) begin
      if (gapped && i > 0) begin
        din_valid = 1'b0;
        din       = 16'hDEAD;
        @(negedge clk);
      end
      din       = (i < 9) ? wb + 16'(i) : ab + 16'(i - 9);
      din_valid = 1'b1;
      wait_sig(sel_b ? 1 : 0, "din_ready");
      @(negedge clk);
    end
    din_valid = 1'b0;
    din       = '0;
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, " cmd_ready"}, a_cmd_ready, 1);
    chk({tag, " din_ready"}, a_din_ready, 0);
    chk({tag, " filt_in"}, a_filt_in, 0);
    chk({tag, " act_in"}, a_act_in, 0);
    chk({tag, " load_en_wght"}, a_load_en_wght, 0);
    chk({tag, " load_en_act"}, a_load_en_act, 0);
    chk({tag, " start"}, a_start, 0);
    chk({tag, " dout"}, a_dout, 0);
    chk({tag, " dout_valid"}, a_dout_valid, 0);
    chk({tag, " busy"}, a_busy, 0);
    chk({tag, " timeout_err"}, a_timeout_err, 0);
  endtask

  task automatic run_a(input int v, input bit hold_cmd);
    mon_w = vecs[v].w_base;
    mon_a = vecs[v].a_base;
    n_w = 0; n_a = 0; n_start = 0;
    mon_en = 1'b1;
    chk("cmd_ready before run", a_cmd_ready, 1);
    cmd_valid_a = 1'b1;
    @(negedge clk);
    if (!hold_cmd) cmd_valid_a = 1'b0;
    chk("busy after cmd", a_busy, 1);
    chk("cmd_ready during run", a_cmd_ready, 0);
    feed(1'b0, vecs[v].w_base, vecs[v].a_base, vecs[v].gapped, 35);
    repeat (2) @(negedge clk);
    chk("start before load_done", a_start, 0);
    load_done = 1'b1;
    @(negedge clk);
    load_done = 1'b0;
    wait_sig(2, "a_start");
    for (int i = 0; i < XD; i++) pe_out[i] = vecs[v].pe[i];
    repeat (20) @(negedge clk);
    chk("dout_valid during compute", a_dout_valid, 0);
    compute_done = 1'b1;
    @(negedge clk);
    compute_done = 1'b0;
    for (int k = 0; k < XD; k++) begin
      wait_sig(4, "a_dout_valid");
      if (k == vecs[v].bp_word) begin
        repeat (vecs[v].bp_len) begin
          dout_ready = 1'b0;
          chk($sformatf("dout held [%0d]", k), a_dout, vecs[v].exp[k]);
          chk("dout_valid held", a_dout_valid, 1);
          @(negedge clk);
        end
      end
      chk($sformatf("vec%0d dout[%0d]", v, k), a_dout, vecs[v].exp[k]);
      dout_ready = 1'b1;
      @(negedge clk);
      dout_ready = 1'b0;
    end
    chk("dout_valid after unload", a_dout_valid, 0);
    chk("busy after unload", a_busy, 0);
    chk("cmd_ready after unload", a_cmd_ready, 1);
    chk("weight pulses", n_w, 9);
    chk("act pulses", n_a, 35);
    chk("start pulses", n_start, 1);
    mon_en = 1'b0;
    if (hold_cmd) begin
      @(negedge clk);
      chk("held cmd re-accepted busy", a_busy, 1);
      chk("held cmd re-accepted din_ready", a_din_ready, 1);
    end
  endtask

  initial begin
    for (int i = 0; i < XD; i++) pe_out[i] = '0;

    // pe/exp packed arrays list index XD-1 first.
    vecs[0].w_base = 16'd1;    vecs[0].a_base = 16'd100;  vecs[0].gapped = 1'b0;
    vecs[0].bp_word = -1;      vecs[0].bp_len = 0;
    vecs[0].pe  = {16'd50, 16'd40, 16'd30, 16'd20, 16'd10};
    vecs[0].exp = {16'd50, 16'd40, 16'd30, 16'd20, 16'd10};
    vecs[1].w_base = 16'd1;    vecs[1].a_base = 16'd100;  vecs[1].gapped = 1'b1;
    vecs[1].bp_word = -1;      vecs[1].bp_len = 0;
    vecs[1].pe  = {16'd50, 16'd40, 16'd30, 16'd20, 16'd10};
    vecs[1].exp = {16'd50, 16'd40, 16'd30, 16'd20, 16'd10};
    vecs[2].w_base = 16'd1;    vecs[2].a_base = 16'd100;  vecs[2].gapped = 1'b0;
    vecs[2].bp_word = 2;       vecs[2].bp_len = 3;
    vecs[2].pe  = {16'd50, 16'd40, 16'd30, 16'd20, 16'd10};
    vecs[2].exp = {16'd50, 16'd40, 16'd30, 16'd20, 16'd10};
    vecs[3].w_base = 16'h7FF8; vecs[3].a_base = 16'hFFE0; vecs[3].gapped = 1'b1;
    vecs[3].bp_word = 0;       vecs[3].bp_len = 2;
    vecs[3].pe  = {16'h1234, 16'd7, 16'h8001, 16'h0000, 16'hFFFF};
    vecs[3].exp = {16'h1234, 16'd7, 16'h8001, 16'h0000, 16'hFFFF};

    repeat (3) @(negedge clk);
    check_reset_a("in reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_a("after release");
    chk("b timeout_err after reset", b_timeout_err, 0);

    for (int v = 0; v < 4; v++) run_a(v, 1'b0);

    // Reset in the middle of LOAD_A after 12 activations.
    mon_w = 16'd1; mon_a = 16'd100; n_w = 0; n_a = 0; n_start = 0;
    mon_en = 1'b1;
    cmd_valid_a = 1'b1;
    @(negedge clk);
    cmd_valid_a = 1'b0;
    feed(1'b0, 16'd1, 16'd100, 1'b0, 12);
    reset = 1'b1;
    @(negedge clk);
    check_reset_a("mid-run reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid-run weight pulses", n_w, 9);
    chk("mid-run act pulses", n_a, 12);
    chk("mid-run start pulses", n_start, 0);
    chk("mid-run idle", a_busy, 0);
    mon_en = 1'b0;
    run_a(0, 1'b0);

    // cmd_valid held high across a whole run.
    run_a(0, 1'b1);
    cmd_valid_a = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Watchdog on instance b: compute_done never comes.
    cmd_valid_b = 1'b1;
    @(negedge clk);
    cmd_valid_b = 1'b0;
    feed(1'b1, 16'd1, 16'd100, 1'b0, 35);
    repeat (2) @(negedge clk);
    load_done = 1'b1;
    @(negedge clk);
    load_done = 1'b0;
    wait_sig(3, "b_start");
    n_dv_b = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) begin
        chk("timeout_err before expiry", b_timeout_err, 0);
        chk("busy before expiry", b_busy, 1);
      end
      if (k == 16) begin
        chk("timeout_err at expiry", b_timeout_err, 1);
        chk("busy after timeout", b_busy, 0);
        chk("cmd_ready after timeout", b_cmd_ready, 1);
      end
    end
    repeat (5) @(negedge clk);
    chk("no dout_valid after timeout", n_dv_b, 0);
    chk("timeout_err sticky", b_timeout_err, 1);
    cmd_valid_b = 1'b1;
    @(negedge clk);
    cmd_valid_b = 1'b0;
    chk("timeout_err cleared by cmd", b_timeout_err, 0);
    chk("busy after new cmd", b_busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_cluster_ctrl.md
PE_CLUSTER_CTRL -- requirements
Module: pe_cluster_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, datapath word width.
REQ-002 SHALL have parameter X_dim, default 5, cluster columns (output words per run).
REQ-003 SHALL have parameter W_WORDS, default 9, weight words per run (kernel_size*Y_dim).
REQ-004 SHALL have parameter A_WORDS, default 35, activation words per run (act_size*(X_dim+Y_dim-1)).
REQ-005 SHALL have parameter TIMEOUT, default 1023, max cycles waiting on load_done or compute_done.
REQ-006 SHALL have ports: clk in 1, single clock; reset in 1, synchronous active-high.
REQ-007 SHALL have ports: cmd_valid in 1, run request; cmd_ready out 1, run accepted when both high.
REQ-008 SHALL have ports: din in DATA_WIDTH, input word stream; din_valid in 1; din_ready out 1.
REQ-009 SHALL have ports: filt_in out DATA_WIDTH and act_in out DATA_WIDTH, cluster data; load_en_wght out 1; load_en_act out 1; start out 1.
REQ-010 SHALL have ports: load_done in 1; compute_done in 1; pe_out in DATA_WIDTH x X_dim unpacked array, cluster results.
REQ-011 SHALL have ports: dout out DATA_WIDTH; dout_valid out 1; dout_ready in 1; busy out 1; timeout_err out 1.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD_W, LOAD_A, WAIT_LOAD, START, COMPUTE, CAPTURE, UNLOAD.
REQ-013 SHALL drive cmd_ready=1 only in IDLE; handshake moves IDLE->LOAD_W, clears timeout_err, zeroes word counter.
REQ-014 SHALL drive din_ready=1 only in LOAD_W/LOAD_A; accepted word = din_valid & din_ready.
REQ-015 SHALL register each accepted word in LOAD_W onto filt_in with load_en_wght=1 in the next cycle; load_en_wght=0 otherwise.
REQ-016 SHALL register each accepted word in LOAD_A onto act_in with load_en_act=1 in the next cycle; load_en_act=0 otherwise.
REQ-017 SHALL count accepted words; W_WORDS-th word moves LOAD_W->LOAD_A (counter reset); A_WORDS-th word moves LOAD_A->WAIT_LOAD.
REQ-018 SHALL tolerate din_valid gaps: no word, no load_en pulse, state held.
REQ-019 SHALL leave WAIT_LOAD for START on first cycle load_done=1, with the final load_en_act pulse already issued.
REQ-020 SHALL assert start for exactly one cycle in START, then enter COMPUTE.
REQ-021 SHALL ignore compute_done on the START cycle; in COMPUTE, compute_done=1 moves to CAPTURE.
REQ-022 SHALL wait exactly one cycle in CAPTURE (cluster output register latency), then latch all X_dim pe_out words into a local buffer and enter UNLOAD.
REQ-023 SHALL present buffered words on dout in index order 0..X_dim-1 with dout_valid=1 in UNLOAD; advance on dout_valid & dout_ready; hold dout stable while dout_ready=0.
REQ-024 SHALL return to IDLE after the X_dim-th transfer; dout_valid=0 outside UNLOAD.
REQ-025 SHALL run a watchdog in WAIT_LOAD and COMPUTE: cleared on state entry; if TIMEOUT cycles elapse without the awaited signal, set timeout_err=1 (sticky until next accepted cmd) and go to IDLE with no start/unload.
REQ-026 SHALL drive busy=1 in every state except IDLE.
REQ-027 SHALL ignore cmd_valid while busy (no queuing).

Reset
REQ-028 SHALL, on reset=1 at a clk edge, enter IDLE from any state and clear counters, watchdog, output buffer.
REQ-029 SHALL reset outputs to: cmd_ready=1 after reset release, din_ready=0, filt_in=0, act_in=0, load_en_wght=0, load_en_act=0, start=0, dout=0, dout_valid=0, busy=0, timeout_err=0.
REQ-030 SHALL abandon a mid-run reset with no further load_en, start or dout_valid pulses.

Verification
REQ-031 Nominal: cmd, 9 weights 1..9, 35 acts 100..134 continuous, load_done after 2 cycles, compute_done 20 cycles after start, pe_out={10,20,30,40,50} -> 9 load_en_wght pulses with filt_in 1..9, 35 load_en_act pulses 100..134, one start pulse, dout 10,20,30,40,50, busy drops.
REQ-032 Gapped input: din_valid toggled 1/0 -> load_en pulses only for accepted words, counts still 9 and 35.
REQ-033 Backpressure: dout_ready low 3 cycles on word 2 -> dout holds 30 with dout_valid=1, no word lost or repeated.
REQ-034 Timeout: compute_done never asserted, TIMEOUT=15 -> timeout_err=1 15 cycles after COMPUTE entry, IDLE, no dout_valid; next cmd clears timeout_err.
REQ-035 Reset mid-LOAD_A after 12 acts -> all outputs at reset values next cycle; new full run then completes correctly.
REQ-036 cmd_valid held high through a run -> exactly one run per IDLE visit; second starts only after return to IDLE.
